// File: rtl/mdu_ex_pkg.sv
// mdu_ex_pkg: shared definitions for the EX-stage multiply/divide unit.
// Holds the md_op encodings, the FSM state type and a small decode helper
// used by both the control path and the stall logic.
`timescale 1ns/1ps
package mdu_ex_pkg;

  // md_op encodings; 6 and 7 are reserved and behave as no-ops.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Long (multi-cycle) operations are exactly the encodings 0..3,
  // which all have the top bit clear.
  function automatic logic is_long_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/mdu_ex_if.sv
// mdu_ex_if: bundle between the ID/EX pipeline register side and the MDU.
//   start, md_op, rs_val, rt_val : EX-stage MDU instruction and its operands
//   md_useD                      : ID-stage instruction touches the MDU
//   busy, stall_req              : MDU status back toward the pipeline
//   hi, lo                       : architectural HI/LO registers
// master = pipeline side driving the operation, slave = the MDU itself.
`timescale 1ns/1ps
interface mdu_ex_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_useD;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, md_useD,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_useD,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational MDU datapath.
//   a, b        : operands latched at the start edge
//   op          : latched md_op (MULT/MULTU/DIV/DIVU)
//   hi_next     : upper product word or remainder
//   lo_next     : lower product word or quotient
//   div_by_zero : divisor is zero, HI/LO must be left untouched
`timescale 1ns/1ps
module mdu_arith
  import mdu_ex_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic [31:0] quot_s;
  logic [31:0] rem_s;

  // Sign-extend to 64 bits before multiplying so the low 64 bits of the
  // product are the exact signed result.
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes and the signs are restored after:
  // quotient truncates toward zero, remainder follows the dividend. The
  // 0x80000000 / -1 corner falls out naturally as lo=0x80000000, hi=0.
  assign a_neg   = (op == MD_DIV) & a[31];
  assign b_neg   = (op == MD_DIV) & b[31];
  assign a_mag   = a_neg ? (32'd0 - a) : a;
  assign b_mag   = b_neg ? (32'd0 - b) : b;
  assign divisor = (b == 32'd0) ? 32'd1 : b_mag;
  assign quot_u  = a_mag / divisor;
  assign rem_u   = a_mag % divisor;
  assign quot_s  = (a_neg ^ b_neg) ? (32'd0 - quot_u) : quot_u;
  assign rem_s   = a_neg ? (32'd0 - rem_u) : rem_u;

  assign div_by_zero = (b == 32'd0);

  // Select the result pair for the latched operation.
  always_comb begin
    hi_next = rem_s;
    lo_next = quot_s;
    case (op)
      MD_MULT:  {hi_next, lo_next} = prod_s;
      MD_MULTU: {hi_next, lo_next} = prod_u;
      default: begin
        hi_next = rem_s;
        lo_next = quot_s;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ex.sv
// mdu_ex: EX-stage multiply/divide unit sitting behind the ID/EX register.
//   clk : pipeline clock, rising edge
//   clr : asynchronous active-high reset
//   mif : mdu_ex_if slave port (operation in, busy/stall/HI/LO out)
// MULT/MULTU run for MULT_CYCLES, DIV/DIVU for DIV_CYCLES, then write HI/LO.
// MTHI/MTLO write in a single edge from IDLE. stall_req holds the next
// MDU-using instruction in ID while a long operation is outstanding.
`timescale 1ns/1ps
module mdu_ex
  import mdu_ex_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     clr,
  mdu_ex_if.slave mif
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_e        state;
  state_e        state_next;
  logic [CW-1:0] counter;
  logic [CW-1:0] counter_next;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [2:0]    op_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          load_ops;
  logic          wr_result;
  logic          wr_hi;
  logic          wr_lo;
  logic [31:0]   hi_next;
  logic [31:0]   lo_next;
  logic          div_by_zero;

  mdu_arith u_arith (
    .a           (a_q),
    .b           (b_q),
    .op          (op_q),
    .hi_next     (hi_next),
    .lo_next     (lo_next),
    .div_by_zero (div_by_zero)
  );

  // Next-state and write-enable decode. New operations are only accepted
  // from IDLE, so a start presented while busy is dropped entirely. The
  // last busy cycle (counter==1) commits the result unless a divide by
  // zero is pending, in which case HI/LO keep their old contents.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    load_ops     = 1'b0;
    wr_result    = 1'b0;
    wr_hi        = 1'b0;
    wr_lo        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mif.start) begin
          case (mif.md_op)
            MD_MULT, MD_MULTU: begin
              load_ops     = 1'b1;
              counter_next = CW'(MULT_CYCLES);
              state_next   = ST_MUL;
            end
            MD_DIV, MD_DIVU: begin
              load_ops     = 1'b1;
              counter_next = CW'(DIV_CYCLES);
              state_next   = ST_DIV;
            end
            MD_MTHI: wr_hi = 1'b1;
            MD_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        counter_next = counter - 1'b1;
        if (counter == CW'(1)) begin
          counter_next = '0;
          state_next   = ST_IDLE;
          wr_result    = !((state == ST_DIV) && div_by_zero);
        end
      end
      default: begin
        state_next   = ST_IDLE;
        counter_next = '0;
      end
    endcase
  end

  // FSM state and cycle counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_IDLE;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // Operand capture at the start edge; later operand changes are ignored.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (load_ops) begin
      a_q  <= mif.rs_val;
      b_q  <= mif.rt_val;
      op_q <= mif.md_op;
    end
  end

  // HI/LO registers: long-op result at completion, or MTHI/MTLO from IDLE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr_result) begin
      hi_q <= hi_next;
      lo_q <= lo_next;
    end else begin
      if (wr_hi) hi_q <= mif.rs_val;
      if (wr_lo) lo_q <= mif.rs_val;
    end
  end

  assign mif.busy      = (state != ST_IDLE);
  assign mif.stall_req = mif.md_useD & (mif.busy | (mif.start & is_long_op(mif.md_op)));
  assign mif.hi        = hi_q;
  assign mif.lo        = lo_q;

endmodule

// File: doc/mdu_ex.md
Name: mdu_ex

Overview:
- EX-stage multiply/divide unit: the reader side of the ID/EX pipeline register.
- Consumes the latched operands (rs and rt register values) and a decoded MDU operation.
- Runs multi-cycle MULT/MULTU/DIV/DIVU into private HI/LO registers and executes MTHI/MTLO.
- Drives a stall request back toward the ID stage, so that a following MDU instruction waits in ID until results are ready.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
- clk  in  1  pipeline clock, rising edge
- clr  in  1  asynchronous active-high reset
- start  in  1  EX-stage instruction is an MDU operation; valid for this cycle
- md_op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (no-op)
- rs_val  in  32  forwarded rs operand (RD1E after forwarding mux)
- rt_val  in  32  forwarded rt operand (RD2E after forwarding mux)
- md_useD  in  1  ID-stage instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
- busy  out  1  long operation in progress
- stall_req  out  1  request to stall IF/ID and flush ID/EX this cycle
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (asynchronous, at any time, including mid-operation):
  - state=IDLE, counter=0, hi=0, lo=0, busy=0, stall_req=0.
  - An in-flight result is discarded.
- State machine: IDLE, MUL, DIV. busy = (state != IDLE).
- IDLE, start=1, md_op in {0,1}:
  - At this edge, latch operands and the signed flag, counter <= MULT_CYCLES, state <= MUL.
- IDLE, start=1, md_op in {2,3}: same as MULT, but counter <= DIV_CYCLES, state <= DIV.
- IDLE, start=1, md_op=4: hi <= rs_val at this edge; state stays IDLE; never busy.
- IDLE, start=1, md_op=5: lo <= rs_val at this edge; state stays IDLE; never busy.
- IDLE, start=1, md_op 6/7: ignored.
- MUL/DIV: counter decrements every edge. At the edge where counter==1:
  - hi/lo <= result, counter <= 0, state <= IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
  - New hi/lo are visible in the cycle after busy falls.
- MULT: {hi,lo} = signed 32x32 -> 64-bit product.
- MULTU: {hi,lo} = unsigned 32x32 -> 64-bit product.
- DIV (signed):
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU: unsigned quotient into lo, remainder into hi.
- Divide by zero:
  - Still busy for DIV_CYCLES.
  - hi/lo unchanged at completion.
- Result arithmetic uses operands latched at the start edge. Operand input changes during busy have no effect.
- start while busy: ignored entirely, including MTHI/MTLO.
  - This cannot occur in a correct pipeline, because stall_req has held the instruction in ID.
  - The bench checks it as a protection case.
- stall_req = md_useD & (busy | (start & md_op in {0..3})). Combinational.
  - Deasserts in the same cycle busy falls, unless a new long start is presented.
- hi/lo outputs are register outputs; there is no bypass of pending results. MFHI/MFLO correctness relies on stall_req.
- No dependence on pipeline flush: an instruction already in EX always completes.

Decomposition:
- Shared package holds:
  - md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - State encodings: ST_IDLE, ST_MUL, ST_DIV.
- One sub-module, mdu_arith: purely combinational.
  - Inputs: latched a, b, op.
  - Outputs: 64-bit {hi_next, lo_next} and a div_by_zero flag.
- mdu_ex keeps the FSM, counter, operand latches and HI/LO.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3:
  - busy high exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF: after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2:
  - After 10 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU 7/0 afterwards: busy 10 cycles, hi/lo unchanged.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 on consecutive cycles:
  - hi/lo update on the next edge each time; busy stays 0.
  - MTHI issued while DIV busy is ignored.
- DIV started with md_useD=1 for the whole operation:
  - stall_req high from the start cycle through the last busy cycle (11 cycles total), then 0.
  - With md_useD=0, stall_req stays 0.
- Assert clr on cycle 3 of a MULT:
  - busy, hi, lo go 0 immediately (asynchronous).
  - After clr deasserts, a new MULTU 2x3 gives lo=6, hi=0.
